// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-requester data-memory arbiter.
package mem_arbiter_pkg;

    localparam int DEPTH_DEFAULT = 128;
    localparam int AW_DEFAULT    = 32;
    localparam int DW_DEFAULT    = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Command as seen at default widths; the arbiter keeps a width-parameterised copy.
    typedef struct packed {
        logic                  we;
        logic [AW_DEFAULT-1:0] addr;
        logic [DW_DEFAULT-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and data-memory signal bundle for mem_arbiter.
// slave: arbiter side. master: requesters plus the data memory.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0, req1;
    logic          we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic          err0, err1;
    logic          MemRead, MemWrite;
    logic [AW-1:0] Address;
    logic [DW-1:0] WriteData;
    logic [DW-1:0] ReadData;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ReadData,
        output gnt0, gnt1, ack0, ack1, rdata0, rdata1, err0, err1,
               MemRead, MemWrite, Address, WriteData
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ReadData,
        input  gnt0, gnt1, ack0, ack1, rdata0, rdata1, err0, err1,
               MemRead, MemWrite, Address, WriteData
    );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the
// requester that did not win last time. Output is one-hot or zero.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    // Combinational pick from current requests and previous winner
    always_comb begin
        gnt    = '0;
        gnt[0] = req[0] & (~req[1] | last_gnt);
        gnt[1] = req[1] & (~req[0] | ~last_gnt);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// One access per two cycles: accept in IDLE, drive memory in BUSY, ack after.
// Optional macro MEM_ARBITER_ADDR_CHECK_EN: commands with addr >= DEPTH skip
// the memory strobes and complete with err = 1, rdata = 0.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          Clk,
    input  logic          Rst_n,
    mem_arbiter_if.slave  bus
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_BUSY = BUSY;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_lat_t;

    logic [0:0]    state;
    cmd_lat_t      cmd_lat;
    logic          win;
    logic          last_gnt;
    logic [1:0]    pick;
    logic          in_range;
    logic          busy;
    logic          gnt0_q, gnt1_q;
    logic          ack0_q, ack1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

    rr_arb2 u_rr_arb2 (
        .req      ({bus.req1, bus.req0}),
        .last_gnt (last_gnt),
        .gnt      (pick)
    );

    assign busy = (state == ST_BUSY);

`ifdef MEM_ARBITER_ADDR_CHECK_EN
    logic err0_q, err1_q;

    assign in_range = (cmd_lat.addr < AW'(DEPTH));
    assign bus.err0 = err0_q;
    assign bus.err1 = err1_q;

    // Error flag pulses alongside the winner's ack
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            err0_q <= 1'b0;
            err1_q <= 1'b0;
        end else begin
            err0_q <= busy & ~win & ~in_range;
            err1_q <= busy &  win & ~in_range;
        end
    end
`else
    assign in_range = 1'b1;
    assign bus.err0 = 1'b0;
    assign bus.err1 = 1'b0;
`endif

    // Strobes decoded from state so a reset edge cannot cut a write short
    assign bus.MemRead   = busy & ~cmd_lat.we & in_range;
    assign bus.MemWrite  = busy &  cmd_lat.we & in_range;
    assign bus.Address   = cmd_lat.addr;
    assign bus.WriteData = cmd_lat.wdata;

    assign bus.gnt0   = gnt0_q;
    assign bus.gnt1   = gnt1_q;
    assign bus.ack0   = ack0_q;
    assign bus.ack1   = ack1_q;
    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;

    // Accept/serve FSM with command latch, handshake pulses and read capture
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state    <= ST_IDLE;
            last_gnt <= 1'b1;
            win      <= 1'b0;
            cmd_lat  <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|pick) begin
                        state    <= ST_BUSY;
                        win      <= pick[1];
                        last_gnt <= pick[1];
                        gnt0_q   <= pick[0];
                        gnt1_q   <= pick[1];
                        if (pick[1])
                            cmd_lat <= '{we: bus.we1, addr: bus.addr1, wdata: bus.wdata1};
                        else
                            cmd_lat <= '{we: bus.we0, addr: bus.addr0, wdata: bus.wdata0};
                    end
                end
                ST_BUSY: begin
                    state <= ST_IDLE;
                    if (win) begin
                        ack1_q <= 1'b1;
                        if (!in_range)
                            rdata1_q <= '0;
                        else if (!cmd_lat.we)
                            rdata1_q <= bus.ReadData;
                    end else begin
                        ack0_q <= 1'b1;
                        if (!in_range)
                            rdata0_q <= '0;
                        else if (!cmd_lat.we)
                            rdata0_q <= bus.ReadData;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 128, meaning the number of data-memory words.
REQ-002 The block SHALL have parameter AW, default 32, meaning the address width on both requester and memory sides.
REQ-003 The block SHALL have parameter DW, default 32, meaning the data width.
REQ-004 The block SHALL have port Clk, input, 1, the single clock, with all logic on its rising edge.
REQ-005 The block SHALL have port Rst_n, input, 1, the reset, which is synchronous and active-low.
REQ-006 The block SHALL have ports req0/req1, input, 1, meaning access request from requester 0 (CPU) / 1 (loader/DMA).
REQ-007 The block SHALL have ports we0/we1, input, 1, meaning 1 = write and 0 = read.
REQ-008 The block SHALL have ports addr0/addr1, input, AW, meaning word address.
REQ-009 The block SHALL have ports wdata0/wdata1, input, DW, meaning write data.
REQ-010 The block SHALL have ports gnt0/gnt1, output, 1, meaning a one-cycle pulse that the request was accepted.
REQ-011 The block SHALL have ports ack0/ack1, output, 1, meaning a one-cycle pulse that the access completed.
REQ-012 The block SHALL have ports rdata0/rdata1, output, DW, meaning registered read data, valid with ack on reads.
REQ-013 The block SHALL have ports err0/err1, output, 1, meaning out-of-range access, valid with ack.
REQ-014 The block SHALL have ports MemRead/MemWrite, output, 1, meaning the data-memory strobes.
REQ-015 The block SHALL have port Address, output, AW, meaning the data-memory word address.
REQ-016 The block SHALL have port WriteData, output, DW, meaning the data-memory write data.
REQ-017 The block SHALL have port ReadData, input, DW, meaning combinational read data returned by the data memory.

Function
REQ-018 The FSM SHALL have states IDLE and BUSY.
REQ-019 In IDLE, if req0 or req1 is sampled high, the block SHALL pick a winner, latch its we/addr/wdata, pulse that requester's gnt in the next cycle, and move to BUSY.
REQ-020 In BUSY, the block SHALL drive the memory from the latched command for exactly one cycle and return to IDLE.
REQ-021 The block SHALL NOT sample new requests while in BUSY, giving a peak throughput of one access per 2 cycles.
REQ-022 MemRead SHALL equal BUSY & ~we_lat, and MemWrite SHALL equal BUSY & we_lat, decoded from state.
REQ-023 Both strobes SHALL be 0 in IDLE.
REQ-024 Address and WriteData SHALL come from the latch and hold their value outside BUSY.
REQ-025 On a read, ReadData SHALL be captured at the end of the BUSY cycle into the winner's rdata register.
REQ-026 For every access, the winner's ack SHALL pulse in the cycle after BUSY.
REQ-027 Latency SHALL be: request sampled at edge 0 -> gnt and BUSY in cycle 1 -> ack/rdata in cycle 2.
REQ-028 The rdata of the non-winner SHALL hold its previous value.
REQ-029 A requester SHALL hold req/we/addr/wdata stable until it sees gnt, and may drop req in the gnt cycle; the block latches on acceptance, so a later change has no effect on the current access.
REQ-030 If req is still high after gnt, it SHALL be treated as a new request at the next IDLE.
REQ-031 Arbitration SHALL be round-robin: a last_gnt bit records the last winner; on a tie the block grants the requester that is not last_gnt; a single request is granted immediately.
REQ-032 last_gnt SHALL reset to 1, so requester 0 wins the first tie.
REQ-033 When addr >= DEPTH, the behaviour SHALL be as set by REQ-038 and REQ-039.

Reset
REQ-034 When Rst_n = 0 at a rising edge, the block SHALL reset: state=IDLE, last_gnt=1, gnt*/ack*/err*=0, rdata*=0, latched addr/wdata/we=0.
REQ-035 Reset in BUSY SHALL drop the pending ack.
REQ-036 Because the strobes are decoded from state, a write in BUSY at that same edge SHALL complete in memory.
REQ-037 The first request after reset release SHALL be sampled at the first edge with Rst_n = 1.

Configuration
REQ-038 With macro MEM_ARBITER_ADDR_CHECK_EN defined, an accepted command with addr >= DEPTH SHALL still take BUSY with MemRead = MemWrite = 0, then pulse ack with err = 1 and rdata = 0.
REQ-039 With MEM_ARBITER_ADDR_CHECK_EN undefined, err0/err1 SHALL be tied 0 and the address SHALL be passed unchecked.

Structure
REQ-040 A shared package mem_arbiter_pkg SHALL hold the state enum (IDLE, BUSY), DEPTH_DEFAULT=128 and a command struct {we, addr, wdata}.
REQ-041 The block SHALL instantiate one sub-module, rr_arb2, a 2-way round-robin pick: inputs req[1:0] and last_gnt, output a one-hot grant.

Verification
REQ-042 The bench SHALL cover: req0 read addr=5 with Mem[5]=0xDEADBEEF -> gnt0 at cycle 1, MemRead=1 and Address=5 at cycle 1, ack0 at cycle 2 with rdata0=0xDEADBEEF, rdata1 unchanged.
REQ-043 The bench SHALL cover: req1 write addr=10 data=0x1234 -> MemWrite=1 for exactly one cycle, ack1; a following req0 read of addr 10 -> rdata0=0x00001234.
REQ-044 The bench SHALL cover: req0 and req1 held high together for 6 cycles after reset -> grants in order 0,1,0 on cycles 1,3,5, with no cycle having both gnt high.
REQ-045 The bench SHALL cover: Rst_n=0 during a BUSY read -> next cycle ack=0, rdata=0, state IDLE; a request after release is served normally.
REQ-046 The bench SHALL cover, with MEM_ARBITER_ADDR_CHECK_EN: req0 write addr=200 -> MemWrite stays 0, ack0 with err0=1; without the macro -> err0 stays 0.
REQ-047 The bench SHALL cover: req0 pulsed one cycle while the block is in BUSY serving req1 -> no gnt0; the request is lost and the requester must hold req.
